// File: rtl/scanline_fetch_if.sv
// Bus bundle for the scanline prefetcher: line request inputs, SRAM read port and FIFO write port.
// The slave modport is the fetcher itself; the master modport is the surrounding timing/SRAM/FIFO side.
interface scanline_fetch_if #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 18,
   parameter int LINE_BITS = 10,
   parameter int COL_BITS  = 10
);
   logic                 line_req;
   logic [LINE_BITS-1:0] line_num;
   logic [ADDR_W-1:0]    plane_base;
   logic [LINE_BITS-1:0] vscroll;
   logic [COL_BITS-1:0]  hscroll;
   logic [ADDR_W-1:0]    ram_addr;
   logic [DATA_W-1:0]    ram_din;
   logic                 ram_ce;
   logic                 ram_oe;
   logic                 ram_we;
   logic                 ram_lb;
   logic                 ram_hb;
   logic [DATA_W-1:0]    fifo_data;
   logic                 fifo_wr;
   logic                 fifo_afull;
   logic                 busy;
   logic                 line_done;
   logic                 overrun;

   modport master (
      output line_req, line_num, plane_base, vscroll, hscroll, ram_din, fifo_afull,
      input  ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb,
      input  fifo_data, fifo_wr, busy, line_done, overrun
   );

   modport slave (
      input  line_req, line_num, plane_base, vscroll, hscroll, ram_din, fifo_afull,
      output ram_addr, ram_ce, ram_oe, ram_we, ram_lb, ram_hb,
      output fifo_data, fifo_wr, busy, line_done, overrun
   );
endinterface

// File: rtl/scanline_fetch.sv
// Scanline prefetcher: fetches one line of pixel words from SRAM into the pixel FIFO per request.
// Define HSCROLL_EN to start each line at column hscroll with in-line address wrap; otherwise column 0.
module scanline_fetch #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 18,
   parameter int LINE_WORDS = 800,
   parameter int NUM_LINES  = 600,
   parameter int LINE_BITS  = 10,
   parameter int COL_BITS   = 10,
   parameter int RD_LATENCY = 2
) (
   input logic             i_clk100,
   input logic             i_reset_n,
   scanline_fetch_if.slave io_bus
);

   localparam int CNT_W = $clog2(LINE_WORDS + 1);

   typedef enum logic [2:0] {IDLE, CALC, FETCH, DRAIN, DONE} state_t;

   state_t                r_state;
   logic [LINE_BITS-1:0]  r_lineNum;
   logic [LINE_BITS-1:0]  r_vscroll;
   logic [ADDR_W-1:0]     r_planeBase;
   logic [ADDR_W-1:0]     r_lineAddr;
   logic [COL_BITS-1:0]   r_col;
   logic [CNT_W-1:0]      r_issueCnt;
   logic [RD_LATENCY-1:0] r_validPipe;
`ifdef HSCROLL_EN
   logic [COL_BITS-1:0]   r_hscroll;
`endif

   logic [LINE_BITS:0]    w_lineSum;
   logic [LINE_BITS-1:0]  w_effLine;
   logic [ADDR_W-1:0]     w_lineAddrCalc;
   logic [ADDR_W-1:0]     w_baseAddr;
   logic [COL_BITS-1:0]   w_startCol;
   logic [COL_BITS-1:0]   w_curCol;
   logic [COL_BITS-1:0]   w_nextCol;
   logic                  w_issue;
   logic                  w_lastIssue;

   // Both operands are below NUM_LINES, so a single conditional subtract is a full modulo.
   assign w_lineSum      = {1'b0, r_lineNum} + {1'b0, r_vscroll};
   assign w_effLine      = (w_lineSum >= (LINE_BITS+1)'(NUM_LINES))
                         ? LINE_BITS'(w_lineSum - (LINE_BITS+1)'(NUM_LINES))
                         : w_lineSum[LINE_BITS-1:0];
   assign w_lineAddrCalc = r_planeBase + ADDR_W'(w_effLine) * ADDR_W'(LINE_WORDS);

`ifdef HSCROLL_EN
   assign w_startCol = r_hscroll;
`else
   assign w_startCol = '0;
`endif

   // CALC issues the first word directly so the first FIFO write lands 2+RD_LATENCY cycles after the request.
   assign w_curCol    = (r_state == CALC) ? w_startCol : r_col;
   assign w_baseAddr  = (r_state == CALC) ? w_lineAddrCalc : r_lineAddr;
   assign w_nextCol   = (w_curCol == COL_BITS'(LINE_WORDS - 1)) ? '0 : w_curCol + 1'b1;
   assign w_issue     = ((r_state == CALC) || (r_state == FETCH)) && !io_bus.fifo_afull;
   assign w_lastIssue = w_issue && (r_issueCnt == CNT_W'(LINE_WORDS - 1));

   assign io_bus.ram_we = 1'b0;
   assign io_bus.ram_lb = 1'b1;
   assign io_bus.ram_hb = 1'b1;

   always_ff @(posedge i_clk100 or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state          <= IDLE;
         r_lineNum        <= '0;
         r_vscroll        <= '0;
         r_planeBase      <= '0;
         r_lineAddr       <= '0;
         r_col            <= '0;
         r_issueCnt       <= '0;
         r_validPipe      <= '0;
`ifdef HSCROLL_EN
         r_hscroll        <= '0;
`endif
         io_bus.ram_addr  <= '0;
         io_bus.ram_ce    <= 1'b0;
         io_bus.ram_oe    <= 1'b0;
         io_bus.fifo_data <= '0;
         io_bus.fifo_wr   <= 1'b0;
         io_bus.busy      <= 1'b0;
         io_bus.line_done <= 1'b0;
         io_bus.overrun   <= 1'b0;
      end else begin
         r_validPipe      <= (r_validPipe << 1) | RD_LATENCY'(w_issue);
         io_bus.fifo_wr   <= r_validPipe[RD_LATENCY-1];
         io_bus.line_done <= 1'b0;

         if (r_validPipe[RD_LATENCY-1]) begin
            io_bus.fifo_data <= io_bus.ram_din;
         end

         if (io_bus.line_req && (r_state != IDLE)) begin
            io_bus.overrun <= 1'b1;
         end

         if (w_issue) begin
            io_bus.ram_addr <= w_baseAddr + ADDR_W'(w_curCol);
            r_issueCnt      <= r_issueCnt + 1'b1;
         end

         if ((r_state == CALC) || (r_state == FETCH)) begin
            r_col <= w_issue ? w_nextCol : w_curCol;
         end

         // DONE keeps busy high for the line_done cycle so a request landing there is refused.
         case (r_state)
            IDLE: begin
               if (io_bus.line_req) begin
                  r_lineNum   <= io_bus.line_num;
                  r_vscroll   <= io_bus.vscroll;
                  r_planeBase <= io_bus.plane_base;
`ifdef HSCROLL_EN
                  r_hscroll   <= io_bus.hscroll;
`endif
                  r_issueCnt  <= '0;
                  io_bus.busy <= 1'b1;
                  r_state     <= CALC;
               end
            end
            CALC: begin
               r_lineAddr    <= w_lineAddrCalc;
               io_bus.ram_ce <= 1'b1;
               io_bus.ram_oe <= 1'b1;
               r_state       <= FETCH;
            end
            FETCH: begin
               io_bus.ram_ce <= 1'b1;
               io_bus.ram_oe <= 1'b1;
               if (w_lastIssue) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               io_bus.ram_ce <= 1'b0;
               io_bus.ram_oe <= 1'b0;
               if (r_validPipe == '0) begin
                  io_bus.line_done <= 1'b1;
                  r_state          <= DONE;
               end
            end
            DONE: begin
               io_bus.busy <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
